// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, opcode classes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // Debug-visible state codes; values are part of the external contract.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Opcode class lives in the two most significant opcode bits.
  typedef logic [1:0] op_class_t;
  localparam op_class_t CLS_ALU    = 2'b00;
  localparam op_class_t CLS_IMM    = 2'b01;
  localparam op_class_t CLS_BRANCH = 2'b10;
  localparam op_class_t CLS_JUMP   = 2'b11;

  // PC source mux select.
  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Register file destination select.
  localparam logic [1:0] REG_DST_RD   = 2'b00;
  localparam logic [1:0] REG_DST_RT   = 2'b01;
  localparam logic [1:0] REG_DST_LINK = 2'b10;

  // Write-back data select.
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  // Default special opcodes for a 6-bit opcode field.
  localparam logic [5:0] DEF_LD_OP   = 6'b010000;
  localparam logic [5:0] DEF_ST_OP   = 6'b011000;
  localparam logic [5:0] DEF_HALT_OP = 6'b111111;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control unit and the datapath/memory side.
// Latency: n/a (wires only).
// Backpressure: memory side stalls the control unit through mem_ready.
interface multicycle_control_fsm_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
);

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                branch_taken;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic [1:0]          reg_dst;
  logic [1:0]          mem_to_reg;
  logic                alu_src;
  logic                halted;
  logic                timeout_err;
  logic [2:0]          state;
  logic [CNT_W-1:0]    retired_count;

  // Control unit side.
  modport master (
    input  opcode, mem_ready, branch_taken,
    output ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src, halted, timeout_err, state, retired_count
  );

  // Datapath / memory side.
  modport slave (
    output opcode, mem_ready, branch_taken,
    input  ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src, halted, timeout_err, state, retired_count
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags when the limit is hit.
// Latency: expired is combinational on the cycle of the MEM_TIMEOUT-th wait.
// Backpressure: none; a MEM_TIMEOUT of 0 never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic waiting,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] countQ;

  // Count waiting cycles; a state change restarts the count for the next wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ <= '0;
    end else if (clr) begin
      countQ <= '0;
    end else if (waiting) begin
      countQ <= countQ + CW'(1);
    end
  end

  // The current cycle is the MEM_TIMEOUT-th wait once MEM_TIMEOUT-1 waits are behind us.
  assign expired = (MEM_TIMEOUT != 0) && waiting && (countQ == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory timeout, halt and retire counter.
// Latency: 3 to 5 states per instruction plus memory wait cycles in FETCH and MEM.
// Backpressure: mem_ready low holds FETCH/MEM; MEM_TIMEOUT consecutive waits trap into ERROR.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int                  OPCODE_W    = 6,
  parameter logic [OPCODE_W-1:0] LD_OP       = OPCODE_W'(DEF_LD_OP),
  parameter logic [OPCODE_W-1:0] ST_OP       = OPCODE_W'(DEF_ST_OP),
  parameter logic [OPCODE_W-1:0] HALT_OP     = OPCODE_W'(DEF_HALT_OP),
  parameter int                  MEM_TIMEOUT = 16,
  parameter int                  CNT_W       = 32
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_fsm_if.master bus
);

  state_t              stateQ;
  state_t              stateNext;
  logic [OPCODE_W-1:0] opQ;
  logic [CNT_W-1:0]    retiredQ;
  logic                timeoutErrQ;
  op_class_t           opClass;
  logic                isLoad;
  logic                isStore;
  logic                isLink;
  logic                retireNow;
  logic                memWaiting;
  logic                timerClr;
  logic                memExpired;

  // Every decision after DECODE is made from the latched opcode, never the live one.
  assign opClass    = opQ[OPCODE_W-1 -: 2];
  assign isLoad     = (opQ == LD_OP);
  assign isStore    = (opQ == ST_OP);
  assign isLink     = (opClass == CLS_JUMP) && opQ[0];
  assign memWaiting = ((stateQ == FETCH) || (stateQ == MEM)) && !bus.mem_ready;
  assign timerClr   = (stateNext != stateQ);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) uWaitTimer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timerClr),
    .waiting(memWaiting),
    .expired(memExpired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= FETCH;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Latch the instruction opcode during its single DECODE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opQ <= '0;
    end else if (stateQ == DECODE) begin
      opQ <= bus.opcode;
    end
  end

  // Retired-instruction counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retiredQ <= '0;
    end else if (retireNow) begin
      retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeoutErrQ <= 1'b0;
    end else if (stateNext == ERROR) begin
      timeoutErrQ <= 1'b1;
    end
  end

  // Flag the clock edge that leaves an instruction's final state.
  always_comb begin
    retireNow = 1'b0;
    case (stateQ)
      EXEC:    retireNow = (opClass == CLS_BRANCH) || ((opClass == CLS_JUMP) && !opQ[0]);
      MEM:     retireNow = isStore && bus.mem_ready;
      WB:      retireNow = 1'b1;
      default: retireNow = 1'b0;
    endcase
  end

  // Next-state decode; mem_ready on the expiry cycle takes priority over the timeout.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      FETCH: begin
        if (bus.mem_ready) begin
          stateNext = DECODE;
        end else if (memExpired) begin
          stateNext = ERROR;
        end
      end
      DECODE: begin
        stateNext = (bus.opcode == HALT_OP) ? HALTED : EXEC;
      end
      EXEC: begin
        case (opClass)
          CLS_BRANCH: stateNext = FETCH;
          CLS_JUMP:   stateNext = isLink ? WB : FETCH;
          default:    stateNext = (isLoad || isStore) ? MEM : WB;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) begin
          stateNext = isLoad ? WB : FETCH;
        end else if (memExpired) begin
          stateNext = ERROR;
        end
      end
      WB:      stateNext = FETCH;
      HALTED:  stateNext = HALTED;
      ERROR:   stateNext = ERROR;
      default: stateNext = FETCH;
    endcase
  end

  // Output decode from state and latched opcode; strobes are forced low while reset is held.
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SRC_INC;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = REG_DST_RD;
    bus.mem_to_reg = MEM_TO_REG_ALU;
    bus.alu_src    = 1'b0;
    case (stateQ)
      FETCH: begin
        // mem_read drops on the completion cycle so it never overlaps ir_write.
        bus.mem_read = !bus.mem_ready;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      EXEC: begin
        bus.alu_src = (opClass == CLS_IMM);
        if (opClass == CLS_BRANCH) begin
          bus.pc_write = bus.branch_taken;
          bus.pc_src   = PC_SRC_BRANCH;
        end else if (opClass == CLS_JUMP) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_JUMP;
        end
      end
      MEM: begin
        bus.mem_read  = isLoad;
        bus.mem_write = isStore;
      end
      WB: begin
        bus.reg_write = 1'b1;
        if (isLink) begin
          bus.reg_dst    = REG_DST_LINK;
          bus.mem_to_reg = MEM_TO_REG_PC;
        end else if (isLoad) begin
          bus.reg_dst    = REG_DST_RT;
          bus.mem_to_reg = MEM_TO_REG_MEM;
        end else if (opClass == CLS_IMM) begin
          bus.reg_dst    = REG_DST_RT;
        end
      end
      default: begin
      end
    endcase
    if (rst) begin
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

  assign bus.state         = stateQ;
  assign bus.halted        = (stateQ == HALTED);
  assign bus.timeout_err   = timeoutErrQ;
  assign bus.retired_count = retiredQ;

endmodule
